// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlb_op_ctrl
// Description : Initiator side of the TLB maintenance interface. Turns one
//               committed TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB instruction into
//               a single-cycle TLB command pulse. It then samples the TLB's
//               combinational response and produces the CSR write-backs, the
//               refetch request and the illegal-instruction exception.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_op_ctrl #(
    parameter int TLB_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // committed instruction
    input  logic                 op_vld,
    output logic                 op_ready,
    input  logic [2:0]           op_type,
    input  logic [4:0]           inv_op,
    input  logic [9:0]           inv_asid,
    input  logic [18:0]          inv_va,
    // current CSR fields
    input  logic [9:0]           csr_asid,
    input  logic [18:0]          csr_ehi_vpn,
    input  logic [TLB_IDX_W-1:0] csr_idx,
    input  logic [5:0]           csr_ps,
    input  logic                 csr_ne,
    // command pulses and operands to the TLB
    output logic                 tlb_srch,
    output logic                 tlb_rd,
    output logic                 tlb_wr,
    output logic                 tlb_fill,
    output logic                 tlb_inv,
    output logic [9:0]           tlb_asid,
    output logic [18:0]          tlb_vpn,
    output logic [TLB_IDX_W-1:0] tlb_idx,
    output logic [5:0]           tlb_ps,
    output logic                 tlb_ne,
    output logic [4:0]           tlb_inv_op,
    output logic [9:0]           tlb_inv_asid,
    output logic [18:0]          tlb_inv_va,
    // TLB responses
    input  logic                 srch_hit,
    input  logic [TLB_IDX_W-1:0] srch_idx,
    input  logic                 rd_en,
    input  logic [5:0]           rd_ps,
    input  logic [18:0]          rd_vpn,
    input  logic [9:0]           rd_asid,
    input  logic [19:0]          rd_ppn0,
    input  logic [5:0]           rd_flags0,
    input  logic [19:0]          rd_ppn1,
    input  logic [5:0]           rd_flags1,
    input  logic                 rd_g,
    // CSR write-back
    output logic                 wb_idx_we,
    output logic                 wb_ne_we,
    output logic                 wb_ps_we,
    output logic                 wb_ehi_we,
    output logic                 wb_elo_we,
    output logic                 wb_asid_we,
    output logic [TLB_IDX_W-1:0] wb_idx,
    output logic                 wb_ne,
    output logic [5:0]           wb_ps,
    output logic [18:0]          wb_vpn,
    output logic [9:0]           wb_asid,
    output logic [19:0]          wb_ppn0,
    output logic [5:0]           wb_flags0,
    output logic [19:0]          wb_ppn1,
    output logic [5:0]           wb_flags1,
    output logic                 wb_g,
    // completion
    output logic                 done,
    output logic                 refetch,
    output logic                 ine_exc
);

    localparam logic [2:0] c_OP_SRCH = 3'd0;
    localparam logic [2:0] c_OP_RD   = 3'd1;
    localparam logic [2:0] c_OP_WR   = 3'd2;
    localparam logic [2:0] c_OP_FILL = 3'd3;
    localparam logic [2:0] c_OP_INV  = 3'd4;
    localparam logic [4:0] c_INV_MAX = 5'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic                   ine_q, ine_d;
    logic                   srch_q, srch_d, rd_q, rd_d, wr_q, wr_d;
    logic                   fill_q, fill_d, inv_q, inv_d;
    logic [9:0]             asid_q, asid_d;
    logic [18:0]            vpn_q, vpn_d;
    logic [TLB_IDX_W-1:0]   idx_q, idx_d;
    logic [5:0]             ps_q, ps_d;
    logic                   ne_q, ne_d;
    logic [4:0]             inv_op_q, inv_op_d;
    logic [9:0]             inv_asid_q, inv_asid_d;
    logic [18:0]            inv_va_q, inv_va_d;
    logic                   idx_we_q, idx_we_d, ne_we_q, ne_we_d, ps_we_q, ps_we_d;
    logic                   ehi_we_q, ehi_we_d, elo_we_q, elo_we_d, asid_we_q, asid_we_d;
    logic [TLB_IDX_W-1:0]   wb_idx_q, wb_idx_d;
    logic                   wb_ne_q, wb_ne_d;
    logic [5:0]             wb_ps_q, wb_ps_d;
    logic [18:0]            wb_vpn_q, wb_vpn_d;
    logic [9:0]             wb_asid_q, wb_asid_d;
    logic [19:0]            wb_ppn0_q, wb_ppn0_d, wb_ppn1_q, wb_ppn1_d;
    logic [5:0]             wb_flags0_q, wb_flags0_d, wb_flags1_q, wb_flags1_d;
    logic                   wb_g_q, wb_g_d;
    logic                   done_q, done_d, refetch_q, refetch_d, ine_exc_q, ine_exc_d;

    // Next-state, command pulse and write-back computation for the op sequencer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ine_d       = ine_q;
        asid_d      = asid_q;
        vpn_d       = vpn_q;
        idx_d       = idx_q;
        ps_d        = ps_q;
        ne_d        = ne_q;
        inv_op_d    = inv_op_q;
        inv_asid_d  = inv_asid_q;
        inv_va_d    = inv_va_q;
        wb_idx_d    = wb_idx_q;
        wb_ne_d     = wb_ne_q;
        wb_ps_d     = wb_ps_q;
        wb_vpn_d    = wb_vpn_q;
        wb_asid_d   = wb_asid_q;
        wb_ppn0_d   = wb_ppn0_q;
        wb_flags0_d = wb_flags0_q;
        wb_ppn1_d   = wb_ppn1_q;
        wb_flags1_d = wb_flags1_q;
        wb_g_d      = wb_g_q;
        // pulses and enables are single-cycle: cleared unless set below
        srch_d      = 1'b0;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        fill_d      = 1'b0;
        inv_d       = 1'b0;
        idx_we_d    = 1'b0;
        ne_we_d     = 1'b0;
        ps_we_d     = 1'b0;
        ehi_we_d    = 1'b0;
        elo_we_d    = 1'b0;
        asid_we_d   = 1'b0;
        done_d      = 1'b0;
        refetch_d   = 1'b0;
        ine_exc_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_vld) begin
                    state_d    = S_ISSUE;
                    op_d       = op_type;
                    asid_d     = csr_asid;
                    vpn_d      = csr_ehi_vpn;
                    idx_d      = csr_idx;
                    ps_d       = csr_ps;
                    ne_d       = csr_ne;
                    inv_op_d   = inv_op;
                    inv_asid_d = inv_asid;
                    inv_va_d   = inv_va;
                    // reserved op codes and out-of-range INVTLB ops never reach the TLB
                    ine_d      = (op_type > c_OP_INV) ||
                                 ((op_type == c_OP_INV) && (inv_op > c_INV_MAX));
                    srch_d     = (op_type == c_OP_SRCH);
                    rd_d       = (op_type == c_OP_RD);
                    wr_d       = (op_type == c_OP_WR);
                    fill_d     = (op_type == c_OP_FILL);
                    inv_d      = (op_type == c_OP_INV) && (inv_op <= c_INV_MAX);
                end
            end
            S_ISSUE: begin
                // TLB responds combinationally to the pulse; capture it now
                state_d = S_RESP;
                done_d  = 1'b1;
                if (ine_q) begin
                    ine_exc_d = 1'b1;
                end else begin
                    case (op_q)
                        c_OP_SRCH: begin
                            ne_we_d = 1'b1;
                            wb_ne_d = ~srch_hit;
                            if (srch_hit) begin
                                idx_we_d = 1'b1;
                                wb_idx_d = srch_idx;
                            end
                        end
                        c_OP_RD: begin
                            ne_we_d     = 1'b1;
                            ps_we_d     = 1'b1;
                            ehi_we_d    = 1'b1;
                            elo_we_d    = 1'b1;
                            asid_we_d   = 1'b1;
                            wb_ne_d     = ~rd_en;
                            // an invalid entry clears every field it would supply
                            wb_ps_d     = rd_en ? rd_ps     : 6'd0;
                            wb_vpn_d    = rd_en ? rd_vpn    : 19'd0;
                            wb_asid_d   = rd_en ? rd_asid   : 10'd0;
                            wb_ppn0_d   = rd_en ? rd_ppn0   : 20'd0;
                            wb_flags0_d = rd_en ? rd_flags0 : 6'd0;
                            wb_ppn1_d   = rd_en ? rd_ppn1   : 20'd0;
                            wb_flags1_d = rd_en ? rd_flags1 : 6'd0;
                            wb_g_d      = rd_en & rd_g;
                        end
                        default: begin
                            // WR, FILL and legal INV change translations
                            refetch_d = 1'b1;
                        end
                    endcase
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            ine_q       <= 1'b0;
            srch_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            fill_q      <= 1'b0;
            inv_q       <= 1'b0;
            asid_q      <= 10'd0;
            vpn_q       <= 19'd0;
            idx_q       <= '0;
            ps_q        <= 6'd0;
            ne_q        <= 1'b0;
            inv_op_q    <= 5'd0;
            inv_asid_q  <= 10'd0;
            inv_va_q    <= 19'd0;
            idx_we_q    <= 1'b0;
            ne_we_q     <= 1'b0;
            ps_we_q     <= 1'b0;
            ehi_we_q    <= 1'b0;
            elo_we_q    <= 1'b0;
            asid_we_q   <= 1'b0;
            wb_idx_q    <= '0;
            wb_ne_q     <= 1'b0;
            wb_ps_q     <= 6'd0;
            wb_vpn_q    <= 19'd0;
            wb_asid_q   <= 10'd0;
            wb_ppn0_q   <= 20'd0;
            wb_flags0_q <= 6'd0;
            wb_ppn1_q   <= 20'd0;
            wb_flags1_q <= 6'd0;
            wb_g_q      <= 1'b0;
            done_q      <= 1'b0;
            refetch_q   <= 1'b0;
            ine_exc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ine_q       <= ine_d;
            srch_q      <= srch_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            fill_q      <= fill_d;
            inv_q       <= inv_d;
            asid_q      <= asid_d;
            vpn_q       <= vpn_d;
            idx_q       <= idx_d;
            ps_q        <= ps_d;
            ne_q        <= ne_d;
            inv_op_q    <= inv_op_d;
            inv_asid_q  <= inv_asid_d;
            inv_va_q    <= inv_va_d;
            idx_we_q    <= idx_we_d;
            ne_we_q     <= ne_we_d;
            ps_we_q     <= ps_we_d;
            ehi_we_q    <= ehi_we_d;
            elo_we_q    <= elo_we_d;
            asid_we_q   <= asid_we_d;
            wb_idx_q    <= wb_idx_d;
            wb_ne_q     <= wb_ne_d;
            wb_ps_q     <= wb_ps_d;
            wb_vpn_q    <= wb_vpn_d;
            wb_asid_q   <= wb_asid_d;
            wb_ppn0_q   <= wb_ppn0_d;
            wb_flags0_q <= wb_flags0_d;
            wb_ppn1_q   <= wb_ppn1_d;
            wb_flags1_q <= wb_flags1_d;
            wb_g_q      <= wb_g_d;
            done_q      <= done_d;
            refetch_q   <= refetch_d;
            ine_exc_q   <= ine_exc_d;
        end
    end

    assign op_ready     = (state_q == S_IDLE);
    assign tlb_srch     = srch_q;
    assign tlb_rd       = rd_q;
    assign tlb_wr       = wr_q;
    assign tlb_fill     = fill_q;
    assign tlb_inv      = inv_q;
    assign tlb_asid     = asid_q;
    assign tlb_vpn      = vpn_q;
    assign tlb_idx      = idx_q;
    assign tlb_ps       = ps_q;
    assign tlb_ne       = ne_q;
    assign tlb_inv_op   = inv_op_q;
    assign tlb_inv_asid = inv_asid_q;
    assign tlb_inv_va   = inv_va_q;
    assign wb_idx_we    = idx_we_q;
    assign wb_ne_we     = ne_we_q;
    assign wb_ps_we     = ps_we_q;
    assign wb_ehi_we    = ehi_we_q;
    assign wb_elo_we    = elo_we_q;
    assign wb_asid_we   = asid_we_q;
    assign wb_idx       = wb_idx_q;
    assign wb_ne        = wb_ne_q;
    assign wb_ps        = wb_ps_q;
    assign wb_vpn       = wb_vpn_q;
    assign wb_asid      = wb_asid_q;
    assign wb_ppn0      = wb_ppn0_q;
    assign wb_flags0    = wb_flags0_q;
    assign wb_ppn1      = wb_ppn1_q;
    assign wb_flags1    = wb_flags1_q;
    assign wb_g         = wb_g_q;
    assign done         = done_q;
    assign refetch      = refetch_q;
    assign ine_exc      = ine_exc_q;

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_op_ctrl
// Description : Directed, table-driven bench for tlb_op_ctrl plus hand-written
//               back-to-back and mid-op reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_vld = 1'b0;
    logic        op_ready;
    logic [2:0]  op_type = 3'd0;
    logic [4:0]  inv_op = 5'd0;
    logic [9:0]  inv_asid = 10'h03F;
    logic [18:0] inv_va = 19'h00100;
    logic [9:0]  csr_asid = 10'h2AA;
    logic [18:0] csr_ehi_vpn = 19'h0BEEF;
    logic [5:0]  csr_idx = 6'd0;
    logic [5:0]  csr_ps = 6'd21;
    logic        csr_ne = 1'b0;
    logic        tlb_srch, tlb_rd, tlb_wr, tlb_fill, tlb_inv;
    logic [9:0]  tlb_asid;
    logic [18:0] tlb_vpn;
    logic [5:0]  tlb_idx, tlb_ps;
    logic        tlb_ne;
    logic [4:0]  tlb_inv_op;
    logic [9:0]  tlb_inv_asid;
    logic [18:0] tlb_inv_va;
    logic        srch_hit = 1'b0;
    logic [5:0]  srch_idx = 6'd0;
    logic        rd_en = 1'b0;
    logic [5:0]  rd_ps = 6'd12;
    logic [18:0] rd_vpn = 19'h1234A;
    logic [9:0]  rd_asid = 10'h155;
    logic [19:0] rd_ppn0 = 20'hABCDE;
    logic [5:0]  rd_flags0 = 6'h2D;
    logic [19:0] rd_ppn1 = 20'h13579;
    logic [5:0]  rd_flags1 = 6'h1B;
    logic        rd_g = 1'b1;
    logic        wb_idx_we, wb_ne_we, wb_ps_we, wb_ehi_we, wb_elo_we, wb_asid_we;
    logic [5:0]  wb_idx, wb_ps, wb_flags0, wb_flags1;
    logic        wb_ne, wb_g;
    logic [18:0] wb_vpn;
    logic [9:0]  wb_asid;
    logic [19:0] wb_ppn0, wb_ppn1;
    logic        done, refetch, ine_exc;

    int checks = 0;
    int errors = 0;

    tlb_op_ctrl #(.TLB_IDX_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_vld(op_vld), .op_ready(op_ready), .op_type(op_type),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
        .csr_asid(csr_asid), .csr_ehi_vpn(csr_ehi_vpn), .csr_idx(csr_idx),
        .csr_ps(csr_ps), .csr_ne(csr_ne),
        .tlb_srch(tlb_srch), .tlb_rd(tlb_rd), .tlb_wr(tlb_wr),
        .tlb_fill(tlb_fill), .tlb_inv(tlb_inv),
        .tlb_asid(tlb_asid), .tlb_vpn(tlb_vpn), .tlb_idx(tlb_idx),
        .tlb_ps(tlb_ps), .tlb_ne(tlb_ne),
        .tlb_inv_op(tlb_inv_op), .tlb_inv_asid(tlb_inv_asid), .tlb_inv_va(tlb_inv_va),
        .srch_hit(srch_hit), .srch_idx(srch_idx),
        .rd_en(rd_en), .rd_ps(rd_ps), .rd_vpn(rd_vpn), .rd_asid(rd_asid),
        .rd_ppn0(rd_ppn0), .rd_flags0(rd_flags0), .rd_ppn1(rd_ppn1),
        .rd_flags1(rd_flags1), .rd_g(rd_g),
        .wb_idx_we(wb_idx_we), .wb_ne_we(wb_ne_we), .wb_ps_we(wb_ps_we),
        .wb_ehi_we(wb_ehi_we), .wb_elo_we(wb_elo_we), .wb_asid_we(wb_asid_we),
        .wb_idx(wb_idx), .wb_ne(wb_ne), .wb_ps(wb_ps), .wb_vpn(wb_vpn),
        .wb_asid(wb_asid), .wb_ppn0(wb_ppn0), .wb_flags0(wb_flags0),
        .wb_ppn1(wb_ppn1), .wb_flags1(wb_flags1), .wb_g(wb_g),
        .done(done), .refetch(refetch), .ine_exc(ine_exc)
    );

    always #5 clk = ~clk;

    logic [4:0] pulses;
    logic [5:0] wes;
    assign pulses = {tlb_srch, tlb_rd, tlb_wr, tlb_fill, tlb_inv};
    assign wes    = {wb_idx_we, wb_ne_we, wb_ps_we, wb_ehi_we, wb_elo_we, wb_asid_we};

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  iop;
        logic [5:0]  cidx;
        logic        hit;
        logic [5:0]  sidx;
        logic        ren;
        logic [4:0]  e_pulse;   // {srch, rd, wr, fill, inv}
        logic [5:0]  e_we;      // {idx, ne, ps, ehi, elo, asid}
        logic        e_ref;
        logic        e_ine;
        logic        e_ne;
        logic [5:0]  e_idx;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic [4:0] iop, input logic [5:0] cidx,
                       input logic hit, input logic [5:0] sidx, input logic ren,
                       input logic [4:0] ep, input logic [5:0] ew, input logic er,
                       input logic ei, input logic ene, input logic [5:0] eidx);
        vec_t v;
        v.op = op; v.iop = iop; v.cidx = cidx; v.hit = hit; v.sidx = sidx; v.ren = ren;
        v.e_pulse = ep; v.e_we = ew; v.e_ref = er; v.e_ine = ei; v.e_ne = ene; v.e_idx = eidx;
        vq.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        op_vld = 1'b1; op_type = v.op; inv_op = v.iop; csr_idx = v.cidx;
        srch_hit = v.hit; srch_idx = v.sidx; rd_en = v.ren;
        @(posedge clk); #1;
        op_vld = 1'b0;
        // ISSUE cycle
        chk("issue_pulse", 32'(pulses), 32'(v.e_pulse));
        chk("issue_ready", 32'(op_ready), 32'd0);
        chk("issue_done", 32'(done), 32'd0);
        chk("tlb_idx", 32'(tlb_idx), 32'(v.cidx));
        chk("tlb_vpn", 32'(tlb_vpn), 32'h0BEEF);
        chk("tlb_asid", 32'(tlb_asid), 32'h2AA);
        if (v.e_pulse[0]) begin
            chk("tlb_inv_op", 32'(tlb_inv_op), 32'(v.iop));
            chk("tlb_inv_asid", 32'(tlb_inv_asid), 32'h03F);
            chk("tlb_inv_va", 32'(tlb_inv_va), 32'h00100);
        end
        @(posedge clk); #1;
        // RESP cycle
        chk("resp_done", 32'(done), 32'd1);
        chk("resp_pulse", 32'(pulses), 32'd0);
        chk("resp_we", 32'(wes), 32'(v.e_we));
        chk("resp_refetch", 32'(refetch), 32'(v.e_ref));
        chk("resp_ine", 32'(ine_exc), 32'(v.e_ine));
        chk("resp_operand_hold", 32'(tlb_idx), 32'(v.cidx));
        if (v.e_we[4]) chk("wb_ne", 32'(wb_ne), 32'(v.e_ne));
        if (v.e_we[5]) chk("wb_idx", 32'(wb_idx), 32'(v.e_idx));
        if (v.op == 3'd1) begin
            chk("wb_vpn",    32'(wb_vpn),    v.ren ? 32'h1234A : 32'd0);
            chk("wb_ppn0",   32'(wb_ppn0),   v.ren ? 32'hABCDE : 32'd0);
            chk("wb_ppn1",   32'(wb_ppn1),   v.ren ? 32'h13579 : 32'd0);
            chk("wb_ps",     32'(wb_ps),     v.ren ? 32'd12    : 32'd0);
            chk("wb_asid",   32'(wb_asid),   v.ren ? 32'h155   : 32'd0);
            chk("wb_flags0", 32'(wb_flags0), v.ren ? 32'h2D    : 32'd0);
            chk("wb_flags1", 32'(wb_flags1), v.ren ? 32'h1B    : 32'd0);
            chk("wb_g",      32'(wb_g),      v.ren ? 32'd1     : 32'd0);
        end
        @(posedge clk); #1;
        chk("idle_ready", 32'(op_ready), 32'd1);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_we", 32'(wes), 32'd0);
    endtask

    logic [4:0] exp_wr_fill [1:6];
    logic       exp_done    [1:6];
    logic       exp_ready   [1:6];

    initial begin
        //   op    iop   cidx  hit sidx  ren pulse     we          ref  ine  ne   idx
        add(3'd0, 5'd0, 6'd3, 1, 6'd37, 0, 5'b10000, 6'b110000, 0,   0,   0,   6'd37);
        add(3'd0, 5'd0, 6'd3, 0, 6'd11, 0, 5'b10000, 6'b010000, 0,   0,   1,   6'd0);
        add(3'd1, 5'd0, 6'd5, 0, 6'd0,  1, 5'b01000, 6'b011111, 0,   0,   0,   6'd0);
        add(3'd1, 5'd0, 6'd5, 0, 6'd0,  0, 5'b01000, 6'b011111, 0,   0,   1,   6'd0);
        add(3'd2, 5'd0, 6'd7, 0, 6'd0,  0, 5'b00100, 6'b000000, 1,   0,   0,   6'd0);
        add(3'd3, 5'd0, 6'd7, 0, 6'd0,  0, 5'b00010, 6'b000000, 1,   0,   0,   6'd0);
        add(3'd4, 5'd5, 6'd1, 0, 6'd0,  0, 5'b00001, 6'b000000, 1,   0,   0,   6'd0);
        add(3'd4, 5'd6, 6'd1, 0, 6'd0,  0, 5'b00001, 6'b000000, 1,   0,   0,   6'd0);
        add(3'd4, 5'd7, 6'd1, 0, 6'd0,  0, 5'b00000, 6'b000000, 0,   1,   0,   6'd0);
        add(3'd6, 5'd0, 6'd2, 0, 6'd0,  0, 5'b00000, 6'b000000, 0,   1,   0,   6'd0);

        // reset state
        #2;
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_pulse", 32'(pulses), 32'd0);
        chk("rst_we", 32'(wes), 32'd0);
        chk("rst_flags", 32'({done, refetch, ine_exc}), 32'd0);
        chk("rst_operands", 32'({tlb_idx, tlb_vpn, tlb_asid, tlb_inv_op}), 32'd0);
        chk("rst_wb_data", 32'(wb_ppn0 | 20'(wb_vpn) | 20'(wb_idx) | 20'(wb_ne)), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vq[i]) run_vec(vq[i]);

        // back-to-back WR then FILL with op_vld held high throughout
        for (int k = 1; k <= 6; k++) begin
            exp_wr_fill[k] = 5'b00000;
            exp_done[k]    = (k == 2) || (k == 5);
            exp_ready[k]   = (k == 3) || (k == 6);
        end
        exp_wr_fill[1] = 5'b00100;
        exp_wr_fill[4] = 5'b00010;
        @(negedge clk);
        op_vld = 1'b1; op_type = 3'd2;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk("b2b_pulse", 32'(pulses), 32'(exp_wr_fill[k]));
            chk("b2b_done", 32'(done), 32'(exp_done[k]));
            chk("b2b_refetch", 32'(refetch), 32'(exp_done[k]));
            chk("b2b_ready", 32'(op_ready), 32'(exp_ready[k]));
            if (k == 1) op_type = 3'd3;
            if (k == 4) op_vld = 1'b0;
        end

        // asynchronous reset during ISSUE of a WR
        @(negedge clk);
        op_vld = 1'b1; op_type = 3'd2; csr_idx = 6'd9;
        @(posedge clk); #1;
        op_vld = 1'b0;
        chk("rstmid_wr_pulse", 32'(tlb_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_wr_drop", 32'(tlb_wr), 32'd0);
        chk("rstmid_idx", 32'(tlb_idx), 32'd0);
        chk("rstmid_ready", 32'(op_ready), 32'd1);
        @(posedge clk); #1;
        chk("rstmid_no_done", 32'({done, refetch, ine_exc}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_release_ready", 32'(op_ready), 32'd1);
        chk("rstmid_release_quiet", 32'({pulses, done, refetch}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // bound on total run time in case the sequence stalls
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
